// File: rtl/hack_div16.sv
// hack_div16 - multi-cycle 16-bit restoring divider for the Hack datapath.
//
// One shift-subtract step per clock: accept (IDLE), 16 iterations (RUN),
// then one result/correction cycle (FIX). Latency is 17 cycles from the
// accepting edge to done, or 1 cycle for a zero divisor.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   start      in   1   request a division (only sampled in IDLE)
//   dividend   in  16   numerator, sampled on the accepting edge
//   divisor    in  16   denominator, sampled on the accepting edge
//   busy       out  1   high from the edge after acceptance to the result edge
//   done       out  1   one-cycle pulse when results are written
//   quotient   out 16   result quotient, held until the next result edge
//   remainder  out 16   result remainder, held until the next result edge
//   div_zero   out  1   divisor was zero; cleared on the next accepted start
//
// Configuration macro: HACK_DIV16_SIGNED_EN
//   defined   -> two's complement operands, quotient truncates toward zero,
//                remainder takes the dividend's sign
//   undefined -> unsigned operands, no sign logic

module hack_div16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg;
  logic [15:0] dvd_reg;        // dividend magnitude; becomes the quotient as it shifts
  logic [15:0] dvs_reg;        // divisor magnitude
  logic [15:0] rem_reg;        // partial remainder (always < divisor between steps)
  logic        zero_reg;
  logic        done_reg;
  logic        div_zero_reg;
  logic [15:0] quotient_reg;
  logic [15:0] remainder_reg;

  logic [15:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic [15:0] q_fix;
  logic [15:0] r_fix;

`ifdef HACK_DIV16_SIGNED_EN
  logic dvd_neg_reg;
  logic dvs_neg_reg;

  assign dvd_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
  assign dvs_mag = divisor[15]  ? (~divisor + 16'd1)  : divisor;
  // Quotient is negative when the signs differ; remainder follows the dividend.
  assign q_fix = (dvd_neg_reg ^ dvs_neg_reg) ? (~dvd_reg + 16'd1) : dvd_reg;
  assign r_fix = dvd_neg_reg ? (~rem_reg + 16'd1) : rem_reg;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = dvd_reg;
  assign r_fix   = rem_reg;
`endif

  // Shifted partial remainder: 17 bits, next dividend MSB enters at bit 0.
  logic [16:0] rem_shift;
  assign rem_shift = {rem_reg, dvd_reg[15]};

  // Trial subtraction rem_shift[15:0] + ~divisor + 1 as a carry chain.
  // The 17-bit difference is non-negative if the shifted-out bit was set or
  // the 16-bit add carries out; in both cases the difference fits in 16 bits.
  logic [16:0] carry;
  logic [15:0] trial_diff;
  logic        trial_ok;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sub
      logic p_bit;
      assign p_bit          = rem_shift[gi] ^ ~dvs_reg[gi];
      assign trial_diff[gi] = p_bit ^ carry[gi];
      assign carry[gi+1]    = (rem_shift[gi] & ~dvs_reg[gi]) | (p_bit & carry[gi]);
    end
  endgenerate

  assign trial_ok = rem_shift[16] | carry[16];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (divisor == 16'd0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (count_reg == 4'd15) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= 4'd0;
      dvd_reg       <= 16'd0;
      dvs_reg       <= 16'd0;
      rem_reg       <= 16'd0;
      zero_reg      <= 1'b0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
      quotient_reg  <= 16'd0;
      remainder_reg <= 16'd0;
`ifdef HACK_DIV16_SIGNED_EN
      dvd_neg_reg   <= 1'b0;
      dvs_neg_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg    <= 4'd0;
            rem_reg      <= 16'd0;
            dvs_reg      <= dvs_mag;
            zero_reg     <= (divisor == 16'd0);
            div_zero_reg <= 1'b0;
            // A zero divisor skips RUN and reports the raw dividend, so keep it unmodified.
            dvd_reg      <= (divisor == 16'd0) ? dividend : dvd_mag;
`ifdef HACK_DIV16_SIGNED_EN
            dvd_neg_reg  <= dividend[15];
            dvs_neg_reg  <= divisor[15];
`endif
          end
        end
        RUN: begin
          rem_reg   <= trial_ok ? trial_diff : rem_shift[15:0];
          dvd_reg   <= {dvd_reg[14:0], trial_ok};
          count_reg <= count_reg + 4'd1;
        end
        FIX: begin
          done_reg      <= 1'b1;
          count_reg     <= 4'd0;
          div_zero_reg  <= zero_reg;
          quotient_reg  <= zero_reg ? 16'hFFFF : q_fix;
          remainder_reg <= zero_reg ? dvd_reg  : r_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_hack_div16.sv
// Directed testbench for hack_div16 with hand-computed expected results.
// Build with +define+HACK_DIV16_SIGNED_EN to exercise the signed variant.

module tb_hack_div16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  hack_div16 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one cycle; returns just after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = 16'hA5A5;  // later operand changes must not matter
    divisor  = 16'h5A5A;
  endtask

  // Called just after the accepting edge. Optionally pokes start mid-run,
  // optionally holds start during the done cycle to chain the next division.
  task automatic wait_done(input logic [15:0] exp_q, input logic [15:0] exp_r,
                           input logic exp_z, input int exp_lat,
                           input bit disturb, input bit chain,
                           input logic [15:0] nxt_a, input logic [15:0] nxt_b);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    check("dz_clear_on_accept", div_zero, 1'b0);
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (disturb && (cycles == 5 || cycles == 10)) begin
        start    = 1'b1;
        dividend = 16'h7777;
        divisor  = 16'h0003;
      end else begin
        start = 1'b0;
      end
      step();
      cycles++;
    end
    start = 1'b0;
    check("latency", cycles, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("busy_at_done", busy, 1'b0);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_zero", div_zero, exp_z);
    $display("div result q=%h r=%h dz=%b latency=%0d", quotient, remainder, div_zero, cycles);
    if (chain) begin
      dividend = nxt_a;
      divisor  = nxt_b;
      start    = 1'b1;
    end
    step();
    start    = 1'b0;
    dividend = 16'hA5A5;
    divisor  = 16'h5A5A;
    check("done_pulse_end", done, 1'b0);
    if (chain) begin
      check("held_quotient", quotient, exp_q);
      check("held_remainder", remainder, exp_r);
      check("chain_busy", busy, 1'b1);
    end
  endtask

  initial begin
    int done_seen;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, 16'd0);
    check("rst_remainder", remainder, 16'd0);
    check("rst_div_zero", div_zero, 1'b0);
    reset = 1'b0;
    step();

    // Basic case
    launch(16'd100, 16'd7);
    wait_done(16'd14, 16'd2, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);

    // Boundaries
    launch(16'hFFFF, 16'd1);
`ifdef HACK_DIV16_SIGNED_EN
    wait_done(16'hFFFF, 16'd0, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);  // -1 / 1
`else
    wait_done(16'hFFFF, 16'd0, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);
`endif
    launch(16'd5, 16'd9);
    wait_done(16'd0, 16'd5, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);

    // Divide by zero, then a valid division clears the flag
    launch(16'h1234, 16'd0);
    wait_done(16'hFFFF, 16'h1234, 1'b1, 1, 1'b0, 1'b0, 16'd0, 16'd0);
    launch(16'd1000, 16'd10);
    wait_done(16'd100, 16'd0, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);

    // Sign handling
    launch(16'hFFF9, 16'd2);
`ifdef HACK_DIV16_SIGNED_EN
    wait_done(16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);
    launch(16'h8000, 16'hFFFF);
    wait_done(16'h8000, 16'h0000, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);
    launch(16'h8001, 16'd0);
    wait_done(16'hFFFF, 16'h8001, 1'b1, 1, 1'b0, 1'b0, 16'd0, 16'd0);
`else
    wait_done(16'h7FFC, 16'h0001, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);
`endif

    // start pulses while busy are ignored
    launch(16'd30000, 16'd123);
    wait_done(16'd243, 16'd111, 1'b0, 17, 1'b1, 1'b0, 16'd0, 16'd0);

    // Back-to-back: start held during the done cycle
    launch(16'd1000, 16'd33);
    wait_done(16'd30, 16'd10, 1'b0, 17, 1'b0, 1'b1, 16'd255, 16'd16);
    wait_done(16'd15, 16'd15, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);

    // Reset after iteration 8 discards the division
    launch(16'd100, 16'd7);
    repeat (8) step();
    reset = 1'b1;
    step();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quotient", quotient, 16'd0);
    check("midrst_remainder", remainder, 16'd0);
    check("midrst_div_zero", div_zero, 1'b0);
    // Reset wins over start on the same edge
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 16'd3;
    step();
    check("rst_over_start_busy", busy, 1'b0);
    start = 1'b0;
    reset = 1'b0;
    done_seen = 0;
    repeat (25) begin
      if (done) done_seen++;
      step();
    end
    check("no_done_after_rst", done_seen, 0);
    launch(16'd100, 16'd7);
    wait_done(16'd14, 16'd2, 1'b0, 17, 1'b0, 1'b0, 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
